// File: rtl/vgpr_pkg.sv
// Shared VGPR file geometry and operand-collector types.
// Imported by the collector and its output FIFO.
package vgpr_pkg;

  localparam int VGPR_ADDR_W  = 10;
  localparam int VGPR_DATA_W  = 32;
  localparam int NUM_RD_PORTS = 3;
  localparam int OPND_W       = 2 * VGPR_DATA_W;

  typedef logic [VGPR_ADDR_W-1:0] vaddr_t;
  typedef logic [VGPR_DATA_W-1:0] vdata_t;
  typedef logic [OPND_W-1:0]      opnd_t;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    CAP
  } coll_state_e;

  // Operand triple; the tag is appended in the collector
  // because its width is a per-instance parameter.
  typedef struct packed {
    opnd_t src0;
    opnd_t src1;
    opnd_t src2;
  } opnd_set_t;

endpackage

// File: rtl/collector_out_fifo.sv
// Small in-order FIFO holding assembled operand bundles.
// Head is zero while empty.
module collector_out_fifo
  import vgpr_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = logic
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

  // Requests are only accepted with a free slot, so CAP
  // can never push into a full FIFO.
  a_no_overflow : assert property (
    @(posedge clk) disable iff (rst)
    push |-> (count < CNT_W'(DEPTH)) || pop
  );

endmodule

// File: rtl/vgpr_operand_collector.sv
// Fetches up to three 32/64b VGPR operands per request and
// queues the assembled bundle for the ALU.
module vgpr_operand_collector
  import vgpr_pkg::*;
#(
  parameter int TAG_W     = 6,
  parameter int OUT_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [9:0]       in_src0_addr,
  input  logic [9:0]       in_src1_addr,
  input  logic [9:0]       in_src2_addr,
  input  logic [2:0]       in_src_en,
  input  logic [2:0]       in_src_wide,
  input  logic [TAG_W-1:0] in_tag,
  output logic [9:0]       rd0_addr,
  output logic [9:0]       rd1_addr,
  output logic [9:0]       rd2_addr,
  input  logic [31:0]      rd0_data,
  input  logic [31:0]      rd1_data,
  input  logic [31:0]      rd2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_src0,
  output logic [63:0]      out_src1,
  output logic [63:0]      out_src2,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

  typedef struct packed {
    opnd_set_t        ops;
    logic [TAG_W-1:0] tag;
  } bundle_t;

  coll_state_e state_q, state_d;

  vaddr_t           src_q [NUM_RD_PORTS];
  vaddr_t           rd_q  [NUM_RD_PORTS];
  vdata_t           lo_q  [NUM_RD_PORTS];
  vdata_t           rd_data [NUM_RD_PORTS];
  opnd_t            opnd  [NUM_RD_PORTS];
  logic [2:0]       en_q;
  logic [2:0]       wide_q;
  logic [TAG_W-1:0] tag_q;

  logic             accept;
  logic             push;
  logic             pop;
  logic             wide_any;
  logic [CNT_W-1:0] count;
  bundle_t          push_b;
  bundle_t          head_b;

  assign rd_data[0] = rd0_data;
  assign rd_data[1] = rd1_data;
  assign rd_data[2] = rd2_data;

  assign in_ready = !rst && (state_q == IDLE)
                  && (count < CNT_W'(OUT_DEPTH));
  assign accept   = in_valid && in_ready;
  assign wide_any = |(en_q & wide_q);
  assign push     = (state_q == CAP);
  assign pop      = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = LO;
      LO:      state_d = wide_any ? HI : CAP;
      HI:      state_d = CAP;
      CAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      en_q    <= '0;
      wide_q  <= '0;
      tag_q   <= '0;
      for (int i = 0; i < NUM_RD_PORTS; i++) begin
        src_q[i] <= '0;
        rd_q[i]  <= '0;
        lo_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        src_q[0] <= in_src0_addr;
        src_q[1] <= in_src1_addr;
        src_q[2] <= in_src2_addr;
        rd_q[0]  <= in_src0_addr;
        rd_q[1]  <= in_src1_addr;
        rd_q[2]  <= in_src2_addr;
        en_q     <= in_src_en;
        wide_q   <= in_src_wide;
        tag_q    <= in_tag;
      end
      // High-word address wraps within the 10-bit VGPR space.
      for (int i = 0; i < NUM_RD_PORTS; i++) begin
        if (state_q == LO && en_q[i] && wide_q[i])
          rd_q[i] <= src_q[i] + VGPR_ADDR_W'(1);
        if (state_q == HI)
          lo_q[i] <= rd_data[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_RD_PORTS; i++) begin
      opnd[i] = '0;
      if (en_q[i])
        opnd[i] = wide_q[i] ? {rd_data[i], lo_q[i]}
                            : {{VGPR_DATA_W{1'b0}}, rd_data[i]};
    end
    push_b          = '0;
    push_b.ops.src0 = opnd[0];
    push_b.ops.src1 = opnd[1];
    push_b.ops.src2 = opnd[2];
    push_b.tag      = tag_q;
  end

  collector_out_fifo #(
    .DEPTH   (OUT_DEPTH),
    .entry_t (bundle_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_b),
    .pop       (pop),
    .head      (head_b),
    .count     (count)
  );

  assign rd0_addr  = rd_q[0];
  assign rd1_addr  = rd_q[1];
  assign rd2_addr  = rd_q[2];
  assign out_valid = (count != '0);
  assign out_src0  = head_b.ops.src0;
  assign out_src1  = head_b.ops.src1;
  assign out_src2  = head_b.ops.src2;
  assign out_tag   = head_b.tag;

endmodule

// File: tb/tb_vgpr_operand_collector.sv
// Randomized bench for vgpr_operand_collector with a
// request-level reference model and directed pins.
module tb_vgpr_operand_collector;

  localparam int TAG_W = 6;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid;
  logic             in_ready;
  logic [9:0]       in_src0_addr, in_src1_addr, in_src2_addr;
  logic [2:0]       in_src_en, in_src_wide;
  logic [TAG_W-1:0] in_tag;
  logic [9:0]       rd0_addr, rd1_addr, rd2_addr;
  logic [31:0]      rd0_data, rd1_data, rd2_data;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_src0, out_src1, out_src2;
  logic [TAG_W-1:0] out_tag;

  always #5 clk = ~clk;

  vgpr_operand_collector #(.TAG_W(TAG_W), .OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src0_addr(in_src0_addr), .in_src1_addr(in_src1_addr),
    .in_src2_addr(in_src2_addr),
    .in_src_en(in_src_en), .in_src_wide(in_src_wide),
    .in_tag(in_tag),
    .rd0_addr(rd0_addr), .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .rd0_data(rd0_data), .rd1_data(rd1_data), .rd2_data(rd2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_src0(out_src0), .out_src1(out_src1), .out_src2(out_src2),
    .out_tag(out_tag)
  );

  // VGPR file: one-cycle read latency.
  logic [31:0] vgpr [1024];
  always @(posedge clk) begin
    rd0_data <= vgpr[rd0_addr];
    rd1_data <= vgpr[rd1_addr];
    rd2_data <= vgpr[rd2_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Reference model: queue of bundles, one request in flight.
  typedef struct {
    logic [63:0]      s0, s1, s2;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t        q[$];
  exp_t        pend;
  bit          inflight = 0;
  int          done_cyc = 0;
  int          acc_cyc  = -10;
  logic [9:0]  acc_a [3];
  logic [2:0]  acc_en, acc_wide;
  logic        exp_rdy;
  logic [29:0] exp_rd;

  function automatic logic [63:0] opnd(logic [9:0] a, logic en, logic w);
    logic [9:0] a1;
    a1 = a + 10'd1;
    if (!en) return 64'h0;
    if (w) return {vgpr[a1], vgpr[a]};
    return {32'h0, vgpr[a]};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_ready", 64'(in_ready), 64'h0);
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_rd_addr", 64'({rd0_addr, rd1_addr, rd2_addr}), 64'h0);
      q.delete();
      inflight = 0;
      acc_cyc  = -10;
    end else begin
      exp_rdy = !inflight && (q.size() < DEPTH);
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
        chk("out_src0", out_src0, q[0].s0);
        chk("out_src1", out_src1, q[0].s1);
        chk("out_src2", out_src2, q[0].s2);
        chk("out_tag", 64'(out_tag), 64'(q[0].tag));
      end
      if (cyc == acc_cyc + 1)
        chk("rd_addr_lo", 64'({rd0_addr, rd1_addr, rd2_addr}),
            64'({acc_a[0], acc_a[1], acc_a[2]}));
      if (cyc == acc_cyc + 2 && |(acc_en & acc_wide)) begin
        for (int i = 0; i < 3; i++)
          exp_rd[(2-i)*10 +: 10] = (acc_en[i] && acc_wide[i]) ?
                                   acc_a[i] + 10'd1 : acc_a[i];
        chk("rd_addr_hi", 64'({rd0_addr, rd1_addr, rd2_addr}), 64'(exp_rd));
      end
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (inflight && cyc == done_cyc) begin
        q.push_back(pend);
        inflight = 0;
      end
      if (in_valid && exp_rdy) begin
        pend.s0  = opnd(in_src0_addr, in_src_en[0], in_src_wide[0]);
        pend.s1  = opnd(in_src1_addr, in_src_en[1], in_src_wide[1]);
        pend.s2  = opnd(in_src2_addr, in_src_en[2], in_src_wide[2]);
        pend.tag = in_tag;
        inflight = 1;
        done_cyc = cyc + ((|(in_src_en & in_src_wide)) ? 3 : 2);
        acc_cyc  = cyc;
        acc_a[0] = in_src0_addr;
        acc_a[1] = in_src1_addr;
        acc_a[2] = in_src2_addr;
        acc_en   = in_src_en;
        acc_wide = in_src_wide;
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic present(logic [9:0] a0, logic [9:0] a1, logic [9:0] a2,
                         logic [2:0] en, logic [2:0] w,
                         logic [TAG_W-1:0] tg);
    in_src0_addr = a0;
    in_src1_addr = a1;
    in_src2_addr = a2;
    in_src_en    = en;
    in_src_wide  = w;
    in_tag       = tg;
    in_valid     = 1'b1;
  endtask

  // Returns at posedge+1 after the accepting edge.
  task automatic wait_acc(output int t);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout actual=0 required=1 cyc=%0d", cyc);
        break;
      end
    end
    t = cyc;
    sync();
    in_valid = 1'b0;
  endtask

  task automatic wait_until(int c);
    forever begin
      @(negedge clk);
      if (cyc >= c) break;
    end
  endtask

  int  t;
  bit  rnd_done;

  initial begin
    in_valid = 0;
    in_src0_addr = 0; in_src1_addr = 0; in_src2_addr = 0;
    in_src_en = 0; in_src_wide = 0; in_tag = 0;
    out_ready = 0;
    for (int i = 0; i < 1024; i++) vgpr[i] = 32'hA000_0000 + i;

    @(negedge clk);
    chk("rst_out_src0", out_src0, 64'h0);
    chk("rst_out_src1", out_src1, 64'h0);
    chk("rst_out_src2", out_src2, 64'h0);
    chk("rst_out_tag", 64'(out_tag), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Narrow fetch
    out_ready = 1;
    present(10'd5, 10'd6, 10'd7, 3'b111, 3'b000, 6'h11);
    wait_acc(t);
    wait_until(t + 1);
    chk("n_ready_t1", 64'(in_ready), 64'h0);
    chk("n_rd_t1", 64'({rd0_addr, rd1_addr, rd2_addr}),
        64'({10'd5, 10'd6, 10'd7}));
    wait_until(t + 2);
    chk("n_ready_t2", 64'(in_ready), 64'h0);
    chk("n_valid_t2", 64'(out_valid), 64'h0);
    wait_until(t + 3);
    chk("n_valid_t3", 64'(out_valid), 64'h1);
    chk("n_src0", out_src0, 64'h0000_0000_A000_0005);
    chk("n_src1", out_src1, 64'h0000_0000_A000_0006);
    chk("n_src2", out_src2, 64'h0000_0000_A000_0007);
    chk("n_tag", 64'(out_tag), 64'h11);

    // Wide with wrap
    sync();
    present(10'd1023, 10'd10, 10'd0, 3'b011, 3'b001, 6'h12);
    wait_acc(t);
    wait_until(t + 1);
    chk("w_rd_lo", 64'({rd0_addr, rd1_addr}), 64'({10'd1023, 10'd10}));
    wait_until(t + 2);
    chk("w_rd_hi", 64'({rd0_addr, rd1_addr}), 64'({10'd0, 10'd10}));
    wait_until(t + 3);
    chk("w_valid_t3", 64'(out_valid), 64'h0);
    wait_until(t + 4);
    chk("w_valid_t4", 64'(out_valid), 64'h1);
    chk("w_src0", out_src0, 64'hA000_0000_A000_03FF);
    chk("w_src1", out_src1, 64'h0000_0000_A000_000A);
    chk("w_src2", out_src2, 64'h0);

    // All sources disabled
    sync();
    present(10'd3, 10'd4, 10'd5, 3'b000, 3'b111, 6'h2A);
    wait_acc(t);
    wait_until(t + 2);
    chk("z_valid_t2", 64'(out_valid), 64'h0);
    wait_until(t + 3);
    chk("z_valid_t3", 64'(out_valid), 64'h1);
    chk("z_srcs", out_src0 | out_src1 | out_src2, 64'h0);
    chk("z_tag", 64'(out_tag), 64'h2A);

    // Backpressure: third request held until a slot frees
    sync();
    out_ready = 0;
    repeat (2) sync();
    present(10'd20, 10'd21, 10'd22, 3'b111, 3'b000, 6'd1);
    wait_acc(t);
    present(10'd30, 10'd31, 10'd32, 3'b101, 3'b100, 6'd2);
    wait_acc(t);
    present(10'd40, 10'd41, 10'd42, 3'b010, 3'b000, 6'd3);
    wait_until(t + 5);
    repeat (4) begin
      @(negedge clk);
      chk("bp_held", 64'(in_ready), 64'h0);
      chk("bp_head", 64'(out_tag), 64'd1);
    end
    sync();
    out_ready = 1;
    @(negedge clk);
    chk("bp_pop1", 64'(out_tag), 64'd1);
    @(negedge clk);
    chk("bp_pop2", 64'(out_tag), 64'd2);
    wait_acc(t);
    wait_until(t + 3);
    chk("bp_pop3", 64'(out_tag), 64'd3);

    // Continuous requests with out_ready high
    sync();
    for (int i = 0; i < 12; i++) begin
      present(10'($urandom), 10'($urandom), 10'($urandom),
              3'($urandom), 3'($urandom), 6'(i + 8));
      wait_acc(t);
    end
    repeat (6) sync();

    // Reset during HI of a wide request, one entry queued
    out_ready = 0;
    present(10'd50, 10'd51, 10'd52, 3'b001, 3'b000, 6'd7);
    wait_acc(t);
    wait_until(t + 3);
    sync();
    present(10'd60, 10'd61, 10'd62, 3'b001, 3'b001, 6'd9);
    wait_acc(t);
    @(posedge clk);
    #1 rst = 1;
    #1;
    chk("r_valid", 64'(out_valid), 64'h0);
    chk("r_rd_addr", 64'({rd0_addr, rd1_addr, rd2_addr}), 64'h0);
    chk("r_ready", 64'(in_ready), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    out_ready = 1;
    @(negedge clk);
    chk("r_ready_after", 64'(in_ready), 64'h1);
    repeat (5) begin
      @(negedge clk);
      chk("r_no_stale", 64'(out_valid), 64'h0);
    end

    // Randomized traffic with random backpressure
    sync();
    for (int i = 0; i < 1024; i++) vgpr[i] = $urandom;
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          present(10'($urandom), 10'($urandom), 10'($urandom),
                  3'($urandom), 3'($urandom), 6'($urandom));
          wait_acc(t);
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) sync();
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          sync();
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1;
    repeat (10) sync();
    chk("drain_empty", 64'(out_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
